hardwired_control_unit: RTL and testbench

Hardwired control sequencer for the CPU datapath. It drives the single-bit strobes that the datapath testbenches currently toggle by hand: PCout, MARin, Gra, BAout, Zin and the rest. It decodes the 5-bit IR opcode returned by the datapath and steps T0..T7 per instruction. It sits directly upstream of the datapath: its outputs connect 1:1 to the datapath's control ports, and the datapath's `operation` and CON flip-flop outputs feed back into it.

---
 rtl/hardwired_control_unit.sv | 217 +++++++++++++++++++++
 tb/tb_hardwired_control_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hardwired_control_unit.sv
// hardwired_control_unit
// Hardwired control sequencer for the CPU datapath. Steps T0..T7 per
// instruction, decoding the IR opcode fed back from the datapath, and drives
// the datapath's single-bit control strobes as a Moore decode of the current
// step qualified by the opcode (and by con_ff in the branch-taken step).
module hardwired_control_unit #(
  parameter int unsigned     OP_W    = 5,
  parameter logic [OP_W-1:0] HALT_OP = 5'b11010
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
  input  logic            con_ff,
  input  logic            stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            Write,
  output logic            IRin,
  output logic            Yin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            ZLowout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            R_in,
  output logic            R_out,
  output logic            BAout,
  output logic            Cout,
  output logic            CONin,
  output logic            HIout,
  output logic            LOout,
  output logic            InPortout,
  output logic            OutPortin,
  output logic            run,
  output logic            illegal_op
);

  // Sequencer states.
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_T7     = 4'd8;
  localparam logic [3:0] S_PAUSE  = 4'd9;
  localparam logic [3:0] S_HALTED = 4'd10;

  // Supported opcodes (halt comes from HALT_OP).
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(5'b10011);
  localparam logic [OP_W-1:0] OP_IN   = OP_W'(5'b10101);
  localparam logic [OP_W-1:0] OP_OUT  = OP_W'(5'b10110);
  localparam logic [OP_W-1:0] OP_MFHI = OP_W'(5'b10111);
  localparam logic [OP_W-1:0] OP_MFLO = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11001);

  logic [3:0] state_q, state_d;
  logic       instr_end;

  logic op_ld, op_st, op_ldi, op_alu, op_alui, op_br;
  logic op_jr, op_in, op_out, op_mfhi, op_mflo;
  logic op_single, op_nop, op_halt, op_legal;

  // Classify the opcode into the instruction families that share step tables.
  always_comb begin
    op_ld     = (opcode == OP_LD);
    op_st     = (opcode == OP_ST);
    op_ldi    = (opcode == OP_LDI);
    op_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                (opcode == OP_AND) || (opcode == OP_OR);
    op_alui   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    op_br     = (opcode == OP_BR);
    op_jr     = (opcode == OP_JR);
    op_in     = (opcode == OP_IN);
    op_out    = (opcode == OP_OUT);
    op_mfhi   = (opcode == OP_MFHI);
    op_mflo   = (opcode == OP_MFLO);
    op_single = op_jr || op_in || op_out || op_mfhi || op_mflo;
    op_nop    = (opcode == OP_NOP);
    op_halt   = (opcode == HALT_OP);
    op_legal  = op_ld || op_st || op_ldi || op_alu || op_alui || op_br ||
                op_single || op_nop || op_halt;
  end

  // Next-step selection; an ending instruction returns to T0 or parks in PAUSE.
  always_comb begin
    state_d   = state_q;
    instr_end = 1'b0;
    case (state_q)
      S_RST:    state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2: begin
        if (op_halt)               state_d   = S_HALTED;
        else if (op_nop || !op_legal) instr_end = 1'b1;
        else                       state_d   = S_T3;
      end
      S_T3: begin
        if (op_single) instr_end = 1'b1;
        else           state_d   = S_T4;
      end
      S_T4:     state_d = S_T5;
      S_T5: begin
        if (op_ldi || op_alu || op_alui) instr_end = 1'b1;
        else                             state_d   = S_T6;
      end
      S_T6: begin
        if (op_br) instr_end = 1'b1;
        else       state_d   = S_T7;
      end
      S_T7:     instr_end = 1'b1;
      S_PAUSE:  if (!stop) state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RST;
    endcase
    if (instr_end) state_d = stop ? S_PAUSE : S_T0;
  end

  // Step register with synchronous clear; clr aborts any instruction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Strobe decode from current step, qualified by opcode family and con_ff.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0; ZLowout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0; BAout = 1'b0;
    Cout = 1'b0; CONin = 1'b0; HIout = 1'b0; LOout = 1'b0;
    InPortout = 1'b0; OutPortin = 1'b0;
    run        = (state_q >= S_T0) && (state_q <= S_T7);
    illegal_op = (state_q == S_T2) && !op_legal;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      S_T3: begin
        if (op_ld || op_st || op_ldi) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (op_alu || op_alui) begin
          Grb = 1'b1; R_out = 1'b1; Yin = 1'b1;
        end else if (op_br) begin
          Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        end else if (op_jr) begin
          Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
        end else if (op_in) begin
          InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (op_out) begin
          Gra = 1'b1; R_out = 1'b1; OutPortin = 1'b1;
        end else if (op_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (op_mflo) begin
          LOout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end
      end
      S_T4: begin
        if (op_ld || op_st || op_ldi || op_alui) begin
          Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end else if (op_alu) begin
          Grc = 1'b1; R_out = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end else if (op_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (op_ld || op_st) begin
          ZLowout = 1'b1; MARin = 1'b1;
        end else if (op_ldi || op_alu || op_alui) begin
          ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (op_br) begin
          Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end
      end
      S_T6: begin
        if (op_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (op_st) begin
          Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1;
        end else if (op_br && con_ff) begin
          ZLowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (op_ld) begin
          MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1;
        end else if (op_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// tb_hardwired_control_unit
// Directed bench for the hardwired control sequencer. A step-indexed
// instruction model predicts every strobe each cycle; directed sequences add
// hand-computed literal expectations for lengths and strobe placement.
module tb_hardwired_control_unit;

  logic       clk, clr, con_ff, stop;
  logic [4:0] opcode;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
  logic ZHighIn, ZLowIn, ZLowout, Gra, Grb, Grc, R_in, R_out, BAout, Cout;
  logic CONin, HIout, LOout, InPortout, OutPortin, run, illegal_op;

  hardwired_control_unit dut (
    .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .ZLowout(ZLowout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout), .Cout(Cout),
    .CONin(CONin), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .OutPortin(OutPortin), .run(run), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit positions of every observed output in dut_vec.
  localparam logic [26:0] K_PCOUT = 27'(1) << 0,  K_PCIN   = 27'(1) << 1,
                          K_INCPC = 27'(1) << 2,  K_MARIN  = 27'(1) << 3,
                          K_MDRIN = 27'(1) << 4,  K_MDROUT = 27'(1) << 5,
                          K_READ  = 27'(1) << 6,  K_WRITE  = 27'(1) << 7,
                          K_IRIN  = 27'(1) << 8,  K_YIN    = 27'(1) << 9,
                          K_ZHI   = 27'(1) << 10, K_ZLO    = 27'(1) << 11,
                          K_ZLOUT = 27'(1) << 12, K_GRA    = 27'(1) << 13,
                          K_GRB   = 27'(1) << 14, K_GRC    = 27'(1) << 15,
                          K_RIN   = 27'(1) << 16, K_ROUT   = 27'(1) << 17,
                          K_BAOUT = 27'(1) << 18, K_COUT   = 27'(1) << 19,
                          K_CONIN = 27'(1) << 20, K_HIOUT  = 27'(1) << 21,
                          K_LOOUT = 27'(1) << 22, K_INPORT = 27'(1) << 23,
                          K_OUTPORT = 27'(1) << 24, K_RUN  = 27'(1) << 25,
                          K_ILL   = 27'(1) << 26;

  logic [26:0] dut_vec;
  assign dut_vec = {illegal_op, run, OutPortin, InPortout, LOout, HIout, CONin,
                    Cout, BAout, R_out, R_in, Grc, Grb, Gra, ZLowout, ZLowIn,
                    ZHighIn, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
                    IncPC, PCin, PCout};

  logic at_t0;
  assign at_t0 = (dut_vec == (K_RUN | K_PCOUT | K_MARIN));

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
                         OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01001,
                         OP_OR = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100,
                         OP_ORI = 5'b01101, OP_BR = 5'b10010, OP_JR = 5'b10011,
                         OP_IN = 5'b10101, OP_OUT = 5'b10110, OP_MFHI = 5'b10111,
                         OP_MFLO = 5'b11000, OP_NOP = 5'b11001, OP_HALT = 5'b11010;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int inst_len(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST: return 8;
      OP_BR: return 7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: return 6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return (op inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                       OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_IN, OP_OUT,
                       OP_MFHI, OP_MFLO, OP_NOP, OP_HALT});
  endfunction

  // Strobes for step s of instruction op (step 0 is T0).
  function automatic logic [26:0] step_mask(input logic [4:0] op, input int s, input logic con);
    if (s == 0) return K_PCOUT | K_MARIN;
    if (s == 1) return K_READ | K_MDRIN;
    if (s == 2) return K_MDROUT | K_IRIN | K_PCIN | K_INCPC;
    case (op)
      OP_LD, OP_ST, OP_LDI: begin
        if (s == 3) return K_GRB | K_BAOUT | K_YIN;
        if (s == 4) return K_COUT | K_ZHI | K_ZLO;
        if (s == 5) return (op == OP_LDI) ? (K_ZLOUT | K_GRA | K_RIN) : (K_ZLOUT | K_MARIN);
        if (s == 6) return (op == OP_LD) ? (K_READ | K_MDRIN) : (K_GRA | K_ROUT | K_MDRIN);
        if (s == 7) return (op == OP_LD) ? (K_MDROUT | K_GRA | K_RIN) : K_WRITE;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        if (s == 3) return K_GRB | K_ROUT | K_YIN;
        if (s == 4) return K_GRC | K_ROUT | K_ZHI | K_ZLO;
        if (s == 5) return K_ZLOUT | K_GRA | K_RIN;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        if (s == 3) return K_GRB | K_ROUT | K_YIN;
        if (s == 4) return K_COUT | K_ZHI | K_ZLO;
        if (s == 5) return K_ZLOUT | K_GRA | K_RIN;
      end
      OP_BR: begin
        if (s == 3) return K_GRA | K_ROUT | K_CONIN;
        if (s == 4) return K_PCOUT | K_YIN;
        if (s == 5) return K_COUT | K_ZHI | K_ZLO;
        if (s == 6) return con ? (K_ZLOUT | K_PCIN) : 27'd0;
      end
      OP_JR:   if (s == 3) return K_GRA | K_ROUT | K_PCIN;
      OP_IN:   if (s == 3) return K_INPORT | K_GRA | K_RIN;
      OP_OUT:  if (s == 3) return K_GRA | K_ROUT | K_OUTPORT;
      OP_MFHI: if (s == 3) return K_HIOUT | K_GRA | K_RIN;
      OP_MFLO: if (s == 3) return K_LOOUT | K_GRA | K_RIN;
      default: ;
    endcase
    return 27'd0;
  endfunction

  typedef enum {M_RST, M_RUN, M_PAUSE, M_HALT} mode_t;
  mode_t m_mode = M_RST;
  int    m_step = 0;
  bit    cmp_en = 1'b0;

  // Model advance on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    if (clr) m_mode = M_RST;
    else begin
      case (m_mode)
        M_RST: begin m_mode = M_RUN; m_step = 0; end
        M_RUN: begin
          if (m_step == 2 && opcode == OP_HALT) m_mode = M_HALT;
          else if (m_step == inst_len(opcode) - 1) begin
            m_step = 0;
            if (stop) m_mode = M_PAUSE;
          end else m_step++;
        end
        M_PAUSE: if (!stop) begin m_mode = M_RUN; m_step = 0; end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [26:0] e;
    if (cmp_en) begin
      e = 27'd0;
      if (m_mode == M_RUN) begin
        e = K_RUN | step_mask(opcode, m_step, con_ff);
        if (m_step == 2 && !is_legal(opcode)) e = e | K_ILL;
      end
      check("cycle_outputs", {5'd0, dut_vec}, {5'd0, e});
    end
  end

  // ---------------- directed stimulus ----------------
  logic [26:0] seq [16];
  int          seq_len;

  // Which captured cycles of the last instruction had any bit of k set.
  function automatic logic [15:0] col(input logic [26:0] k);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < seq_len; i++) if ((seq[i] & k) != 27'd0) r[i] = 1'b1;
    return r;
  endfunction

  // Run one instruction from a T0, capturing each cycle until the next T0 or run=0.
  task automatic run_instr(input logic [4:0] op, input logic con,
                           input int stop_step, input int clr_step);
    int n;
    bit done;
    for (int g = 0; g < 8 && !at_t0; g++) @(negedge clk);
    check("align_t0", {31'd0, at_t0}, 32'd1);
    n = 0;
    done = 1'b0;
    seq[0] = dut_vec;
    #1;
    opcode = op;
    con_ff = con;
    for (int g = 0; g < 14; g++) begin
      @(negedge clk);
      if (at_t0 || !run) begin done = 1'b1; break; end
      n++;
      seq[n] = dut_vec;
      if (n == stop_step) begin #1; stop = 1'b1; end
      if (n == clr_step)  begin #1; clr  = 1'b1; end
    end
    check("instr_bounded", {31'd0, done}, 32'd1);
    seq_len = n + 1;
  endtask

  localparam logic [4:0] V_OP  [13] = '{OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
                                        OP_ORI, OP_JR, OP_IN, OP_OUT, OP_MFHI,
                                        OP_MFLO, OP_NOP, OP_LD};
  localparam int         V_LEN [13] = '{6, 6, 6, 6, 6, 6, 4, 4, 4, 4, 4, 3, 8};

  initial begin
    logic [26:0] acc;
    clr = 1'b1; opcode = OP_LDI; con_ff = 1'b0; stop = 1'b0;
    @(posedge clk); #1 cmp_en = 1'b1;
    @(negedge clk); check("reset_quiet_1", {5'd0, dut_vec}, 32'd0);
    @(posedge clk);
    @(negedge clk); check("reset_quiet_2", {5'd0, dut_vec}, 32'd0);
    #1 clr = 1'b0;

    // ldi r1,7
    run_instr(OP_LDI, 1'b0, -1, -1);
    check("ldi_len", seq_len, 6);
    check("ldi_t5", {5'd0, seq[5]}, {5'd0, K_RUN | K_ZLOUT | K_GRA | K_RIN});
    check("ldi_run_all", {16'd0, col(K_RUN)}, 32'h3f);
    check("ldi_next_t0", {31'd0, at_t0}, 32'd1);

    // st
    run_instr(OP_ST, 1'b0, -1, -1);
    check("st_len", seq_len, 8);
    check("st_write_cycles", {16'd0, col(K_WRITE)}, 32'h80);
    check("st_mdrin_cycles", {16'd0, col(K_MDRIN)}, 32'h42);
    check("st_read_t6", {5'd0, seq[6] & K_READ}, 32'd0);

    // br not taken, then taken
    run_instr(OP_BR, 1'b0, -1, -1);
    check("br0_len", seq_len, 7);
    check("br0_pcin_cycles", {16'd0, col(K_PCIN)}, 32'h04);
    run_instr(OP_BR, 1'b1, -1, -1);
    check("br1_len", seq_len, 7);
    check("br1_pcin_cycles", {16'd0, col(K_PCIN)}, 32'h44);

    // halt, 20 quiet cycles, clr pulse restarts at T0
    run_instr(OP_HALT, 1'b0, -1, -1);
    check("halt_len", seq_len, 3);
    acc = 27'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = acc | dut_vec;
    end
    check("halted_quiet", {5'd0, acc}, 32'd0);
    #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
    @(negedge clk); check("halt_restart_t0", {31'd0, at_t0}, 32'd1);

    // add with stop raised at T4: completes T5, then PAUSE
    run_instr(OP_ADD, 1'b0, 4, -1);
    check("add_stop_len", seq_len, 6);
    check("add_t5", {5'd0, seq[5]}, {5'd0, K_RUN | K_ZLOUT | K_GRA | K_RIN});
    check("pause_run", {31'd0, run}, 32'd0);
    @(negedge clk); check("pause_hold", {5'd0, dut_vec}, 32'd0);
    #1 stop = 1'b0;
    @(negedge clk); check("pause_exit_t0", {31'd0, at_t0}, 32'd1);

    // remaining families with hand-counted lengths
    for (int i = 0; i < 13; i++) begin
      run_instr(V_OP[i], 1'b0, -1, -1);
      check($sformatf("len_op_%b", V_OP[i]), seq_len, V_LEN[i]);
    end

    // ld aborted by clr during T6, then an unsupported opcode
    run_instr(OP_LD, 1'b0, -1, 6);
    check("ld_abort_len", seq_len, 7);
    check("ld_abort_quiet", {5'd0, dut_vec & (K_WRITE | K_RIN | K_RUN)}, 32'd0);
    #1 clr = 1'b0;
    run_instr(5'b11111, 1'b0, -1, -1);
    check("illegal_len", seq_len, 3);
    check("illegal_pulse_cycles", {16'd0, col(K_ILL)}, 32'h04);
    check("illegal_next_t0", {31'd0, at_t0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
